// File: rtl/ltl_event_logger_if.sv
// ---------------------------------------------------------------------------
// ltl_event_logger_if
//   Valid/ready event stream carrying logged LTL property events from the
//   logger to its consumer.
//
//   Parameters
//     TS_W      timestamp width; an event word is TS_W+16 bits wide
//
//   Signals
//     evt_valid  producer -> consumer : head entry available
//     evt_ready  consumer -> producer : consumer accepts the head entry
//     evt_data   producer -> consumer : {timestamp, 3'b000, flags[12:0]}
//
//   Modports
//     master  the logger (drives valid/data, samples ready)
//     slave   the consumer (samples valid/data, drives ready)
// ---------------------------------------------------------------------------
interface ltl_event_logger_if #(
  parameter int TS_W = 16
);
  logic              evt_valid;
  logic              evt_ready;
  logic [TS_W+15:0]  evt_data;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );
endinterface

// File: rtl/ltl_event_logger.sv
// ---------------------------------------------------------------------------
// ltl_event_logger
//   Timestamps the 13 property outputs of the cluster-6 LTL monitor and
//   queues every non-zero capture in a small FIFO for a valid/ready consumer.
//   Keeps a sticky OR of everything captured and a sticky overflow bit that
//   records dropped captures.
//
//   Parameters
//     DEPTH  FIFO entries (power of two, >= 2)
//     TS_W   timestamp width in bits
//
//   Ports
//     clk           single clock, all state on its rising edge
//     reset         asynchronous active-low reset
//     run           monitor active; timestamp advances and captures happen
//                   only while high
//     ltl_flags     bit i = property output ltl<i>c6
//     clear         synchronous clear of sticky_flags and overflow
//     evt           event stream (master modport): evt_valid, evt_ready,
//                   evt_data = {timestamp, 3'b000, flags[12:0]}
//     fifo_level    current FIFO entry count, 0..DEPTH
//     sticky_flags  OR of all captures since reset or clear
//     overflow      sticky: at least one capture was dropped
//
//   Build option
//     LTL_EVENT_EDGE_EN  when defined, only rising property flags are
//                        captured (cap = ltl_flags & ~flags_q); otherwise
//                        every cycle with any flag high is captured.
// ---------------------------------------------------------------------------
module ltl_event_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [12:0]                ltl_flags,
  input  logic                       clear,
  ltl_event_logger_if.master         evt,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [12:0]                sticky_flags,
  output logic                       overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = TS_W + 16;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // DEPTH is a power of two, so a plain increment wraps modulo DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1);
  endfunction

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [TS_W-1:0] ts,
    input logic [12:0]     flags
  );
    return {ts, 3'b000, flags};
  endfunction

  logic [TS_W-1:0]    r_ts;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [12:0]        r_sticky;
  logic               r_overflow;
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  logic [12:0]        w_cap;
  logic               w_push_req;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;

  // Capture stage: what this cycle contributes to the log.
`ifdef LTL_EVENT_EDGE_EN
  logic [12:0]        r_flags_q;

  // Previous flags advance only while the monitor runs, so a flag that is
  // still high after a run=0 gap is not reported as a new rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags_q <= '0;
    end else if (run) begin
      r_flags_q <= ltl_flags;
    end
  end

  assign w_cap = run ? (ltl_flags & ~r_flags_q) : 13'd0;
`else
  assign w_cap = run ? ltl_flags : 13'd0;
`endif

  assign w_push_req = |w_cap;
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == FULL_LVL);
  assign w_pop      = !w_empty && evt.evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Timestamp stage: the entry pushed this cycle carries the value before
  // the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts <= '0;
    end else if (run) begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  // FIFO storage stage: contents are qualified by r_level, so the array
  // itself needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pack_entry(r_ts, w_cap);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Status stage: clear restarts the sticky state from this cycle's
  // capture, and a drop in the clearing cycle still raises overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sticky   <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_sticky   <= w_cap;
      r_overflow <= w_drop;
    end else begin
      r_sticky   <= r_sticky | w_cap;
      r_overflow <= r_overflow | w_drop;
    end
  end

  // Output stage: data is forced to zero whenever the FIFO is empty so the
  // bus reads 0 straight out of reset regardless of stale storage.
  assign evt.evt_valid = !w_empty;
  assign evt.evt_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_level    = r_level;
  assign sticky_flags  = r_sticky;
  assign overflow      = r_overflow;

endmodule

// File: doc/ltl_event_logger.md
LTL_EVENT_LOGGER -- requirements
Module: ltl_event_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter TS_W, default 16, giving the timestamp width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port run, input, 1, monitor active; same run that gates the upstream automata.
REQ-006 SHALL have port ltl_flags, input, 13, bit i = property output ltl<i>c6 of the cluster-6 top module.
REQ-007 SHALL have port clear, input, 1, synchronous clear of sticky_flags and overflow.
REQ-008 SHALL have port evt_valid, output, 1, head FIFO entry available.
REQ-009 SHALL have port evt_ready, input, 1, consumer accepts the head entry.
REQ-010 SHALL have port evt_data, output, TS_W+16, {timestamp, 3'b000, flags[12:0]} of the head entry.
REQ-011 SHALL have port fifo_level, output, clog2(DEPTH)+1, current entry count, 0..DEPTH.
REQ-012 SHALL have port sticky_flags, output, 13, OR of all captured flag vectors since reset or clear.
REQ-013 SHALL have port overflow, output, 1, sticky: at least one capture was dropped.

Function
REQ-014 SHALL keep a TS_W-bit timestamp counter: +1 each cycle with run=1, hold with run=0, wrap from all-ones to 0.
REQ-015 SHALL form a capture vector cap each cycle with run=1 (see REQ-029/030); with run=0, cap = 0.
REQ-016 SHALL request a push when cap != 0; the entry holds the pre-increment timestamp value of that cycle and cap.
REQ-017 SHALL assert evt_valid exactly when fifo_level != 0; evt_data = head entry.
REQ-018 SHALL have latency 1: a capture in cycle N on an empty FIFO gives evt_valid=1 in cycle N+1.
REQ-019 SHALL pop on evt_valid & evt_ready; evt_data SHALL remain stable while evt_valid & !evt_ready.
REQ-020 SHALL treat evt_ready with evt_valid=0 as a no-op.
REQ-021 SHALL, on simultaneous push and pop, perform both; fifo_level is unchanged, including when full.
REQ-022 SHALL, on a push when full with no pop, drop the new entry, keep the FIFO contents, and set overflow.
REQ-023 SHALL update sticky_flags |= cap every cycle, including cycles whose entry is dropped.
REQ-024 SHALL, on clear, load sticky_flags with the same-cycle cap (new flags win) and clear overflow, unless a drop occurs that cycle, in which case overflow SHALL be 1.
REQ-025 SHALL NOT let clear affect FIFO contents, fifo_level or the timestamp.
REQ-026 SHALL wrap FIFO read and write pointers modulo DEPTH; full and empty are distinguished by fifo_level.

Reset
REQ-027 SHALL, on reset low, immediately and asynchronously clear: timestamp, FIFO pointers, fifo_level, sticky_flags, overflow and the edge register; evt_valid=0 and evt_data=0.
REQ-028 SHALL discard in-flight entries on reset mid-operation; the first capture after release carries timestamp 0 if run=1 in that cycle.

Configuration
REQ-029 SHALL, with macro LTL_EVENT_EDGE_EN defined, use cap = ltl_flags & ~flags_q. flags_q loads ltl_flags on cycles with run=1 and holds otherwise. Only rising property flags are logged.
REQ-030 SHALL, without LTL_EVENT_EDGE_EN, use cap = ltl_flags (level capture: one entry per cycle while any flag is high); no flags_q register exists.

Verification
REQ-031 Reset release, run=1, ltl_flags=13'h0004 for 1 cycle at timestamp 5 -> next cycle evt_valid=1, evt_data={16'h0005,3'b0,13'h0004}, fifo_level=1.
REQ-032 evt_ready=0, DEPTH=4, five capture cycles -> fifo_level=4, overflow=1, head entry = first capture; clear=1 -> overflow=0, FIFO intact.
REQ-033 Full FIFO, capture and evt_ready=1 in the same cycle -> fifo_level stays 4, overflow stays 0, new tail = new capture.
REQ-034 LTL_EVENT_EDGE_EN defined, ltl_flags=13'h1001 held for 3 cycles -> exactly one entry; without the macro -> three entries with consecutive timestamps.
REQ-035 Timestamp at 16'hFFFF, captures on two consecutive cycles -> entries carry FFFF then 0000; run=0 for 2 cycles -> no entries and the timestamp holds.
REQ-036 Reset asserted while fifo_level=3 and evt_valid=1 -> evt_valid=0, fifo_level=0 and sticky_flags=0 without waiting for a clk edge.
